// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: matrix drive/sense plus accepted-key outputs.
interface keypad_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keypad_data;
  logic       keypad_enable;
  logic       key_held;
  logic       multi_key;

  // Scanner side: drives columns and key status, senses rows.
  modport master (
    input  row_in,
    output col_out,
    output keypad_data,
    output keypad_enable,
    output key_held,
    output multi_key
  );

  // Keypad/consumer side.
  modport slave (
    output row_in,
    input  col_out,
    input  keypad_data,
    input  keypad_enable,
    input  key_held,
    input  multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with per-frame debounce and one pulse per press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20
) (
  input  logic clk,
  input  logic reset,
  keypad_if.master kp
);

  localparam int unsigned SLOT_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEB_TGT   = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [3:0]          col_q, col_d;
  logic [3:0]          row_s1_q, row_s2_q;
  logic [1:0]          frame_cnt_q, frame_cnt_d;
  logic [3:0]          frame_code_q, frame_code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          cand_q, cand_d;
  logic [3:0]          data_q, data_d;
  logic                en_q, en_d;
  logic                held_q, held_d;
  logic                multi_q, multi_d;

  logic                slot_end, frame_end, single, hit;
  logic [1:0]          acc_cnt;
  logic [3:0]          acc_code;
  logic [CNT_W-1:0]    cnt_inc;

  // Fold the current column's sampled rows into the running frame tally.
  always_comb begin
    acc_cnt  = frame_cnt_q;
    acc_code = frame_code_q;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        if (acc_cnt == 2'd0) acc_code = {2'(r), col_idx_q};
        if (acc_cnt != 2'd2) acc_cnt = 2'(acc_cnt + 2'd1);
      end
    end
  end

  // Column slot timing, frame accumulation and the debounce state machine.
  always_comb begin
    slot_d       = slot_q;
    col_idx_d    = col_idx_q;
    col_d        = col_q;
    frame_cnt_d  = frame_cnt_q;
    frame_code_d = frame_code_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    data_d       = data_q;
    en_d         = 1'b0;
    held_d       = held_q;
    multi_d      = multi_q;

    slot_end  = (slot_q == SLOT_LAST);
    frame_end = slot_end && (col_idx_q == 2'd3);
    single    = (acc_cnt == 2'd1);
    hit       = single && (acc_code == cand_q);
    cnt_inc   = CNT_W'(cnt_q + CNT_W'(1));

    if (slot_end) begin
      slot_d    = '0;
      col_idx_d = 2'(col_idx_q + 2'd1);
      col_d     = ~(4'(4'b0001 << col_idx_d));
      if (frame_end) begin
        frame_cnt_d  = '0;
        frame_code_d = '0;
      end else begin
        frame_cnt_d  = acc_cnt;
        frame_code_d = acc_code;
      end
    end else begin
      slot_d = SLOT_W'(slot_q + SLOT_W'(1));
    end

    if (frame_end) begin
      multi_d = (acc_cnt == 2'd2);
      unique case (state_q)
        IDLE: begin
          if (single) begin
            cand_d = acc_code;
            if (DEB_TGT == CNT_W'(1)) begin
              state_d = PRESSED;
              cnt_d   = '0;
              data_d  = acc_code;
              en_d    = 1'b1;
              held_d  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (hit) begin
            if (cnt_inc == DEB_TGT) begin
              state_d = PRESSED;
              cnt_d   = '0;
              data_d  = cand_q;
              en_d    = 1'b1;
              held_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (!hit) begin
            if (DEB_TGT == CNT_W'(1)) begin
              state_d = IDLE;
              cnt_d   = '0;
              held_d  = 1'b0;
            end else begin
              state_d = RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (hit) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == DEB_TGT) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers, including the two-flop row synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      col_idx_q    <= '0;
      col_q        <= 4'b1110;
      row_s1_q     <= 4'b1111;
      row_s2_q     <= 4'b1111;
      frame_cnt_q  <= '0;
      frame_code_q <= '0;
      cnt_q        <= '0;
      cand_q       <= '0;
      data_q       <= '0;
      en_q         <= 1'b0;
      held_q       <= 1'b0;
      multi_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      row_s1_q     <= kp.row_in;
      row_s2_q     <= row_s1_q;
      frame_cnt_q  <= frame_cnt_d;
      frame_code_q <= frame_code_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      data_q       <= data_d;
      en_q         <= en_d;
      held_q       <= held_d;
      multi_q      <= multi_d;
    end
  end

  assign kp.col_out       = col_q;
  assign kp.keypad_data   = data_q;
  assign kp.keypad_enable = en_q;
  assign kp.key_held      = held_q;
  assign kp.multi_key     = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 (16-cycle frames).
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] keys = '0;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] data;
    int         at_cyc;
  } exp_t;

  exp_t sb_q[$];

  keypad_if kif();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kif.master)
  );

  always #5 clk = ~clk;

  // Cycle count since the last reset edge; frame k ends at cyc 16k+15.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  // Keypad matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.col_out[c]) rows[r] = 1'b0;
    kif.row_in = rows;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at cyc=%0d", name, act, req, cyc);
    end
  endtask

  task automatic goto_cyc(input int c);
    int guard = 0;
    while (cyc != c && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      total++;
      bad++;
      $display("FAIL goto_cyc: actual=%0d required=%0d", cyc, c);
    end
  endtask

  task automatic push(input logic [3:0] d, input int at);
    exp_t e;
    e.data   = d;
    e.at_cyc = at;
    sb_q.push_back(e);
  endtask

  // Monitor: every enable pulse must match the next expected press, in data and timing.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && kif.keypad_enable === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: actual data=%0h required=no pulse at cyc=%0d",
                   kif.keypad_data, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (kif.keypad_data !== e.data || cyc != e.at_cyc) begin
            bad++;
            $display("FAIL pulse: actual data=%0h cyc=%0d required data=%0h cyc=%0d",
                     kif.keypad_data, cyc, e.data, e.at_cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and column sequencing with no keys.
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(kif.col_out), 32'h e);
    chk("rst_data", 32'(kif.keypad_data), 32'h0);
    chk("rst_en", 32'(kif.keypad_enable), 32'h0);
    chk("rst_held", 32'(kif.key_held), 32'h0);
    chk("rst_multi", 32'(kif.multi_key), 32'h0);
    reset = 1'b0;
    goto_cyc(4);   chk("col1", 32'(kif.col_out), 32'h d);
    goto_cyc(8);   chk("col2", 32'(kif.col_out), 32'h b);
    goto_cyc(12);  chk("col3", 32'(kif.col_out), 32'h7);
    goto_cyc(16);  chk("col0_wrap", 32'(kif.col_out), 32'h e);

    // Press key 9 at frame 20; accepted after frames 20..22.
    goto_cyc(320);
    keys[9] = 1'b1;
    push(4'h9, 368);
    goto_cyc(367); chk("held_before_9", 32'(kif.key_held), 32'h0);
    goto_cyc(384); chk("held_9", 32'(kif.key_held), 32'h1);
    goto_cyc(528); chk("held_9_long", 32'(kif.key_held), 32'h1);

    // Release 9 at frame 33; held falls after three empty frames.
    keys[9] = 1'b0;
    goto_cyc(575); chk("held_pre_fall", 32'(kif.key_held), 32'h1);
    goto_cyc(576); chk("held_fall", 32'(kif.key_held), 32'h0);

    // Press key 3; then one-frame glitch release at frame 40.
    keys[3] = 1'b1;
    push(4'h3, 624);
    goto_cyc(640); keys[3] = 1'b0;
    goto_cyc(656); keys[3] = 1'b1;
    goto_cyc(704); chk("held_after_glitch", 32'(kif.key_held), 32'h1);
    keys[3] = 1'b0;
    goto_cyc(752); chk("held_3_fall", 32'(kif.key_held), 32'h0);

    // Bouncing key 2 on alternating frames 47..54.
    for (int f = 0; f < 8; f++) begin
      goto_cyc(752 + 16*f);
      keys[2] = (f % 2 == 0);
    end
    goto_cyc(880);
    keys[2] = 1'b0;
    chk("bounce_held", 32'(kif.key_held), 32'h0);
    chk("bounce_data", 32'(kif.keypad_data), 32'h3);

    // Two keys together for 5 frames, then drop one.
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    goto_cyc(896); chk("multi_on", 32'(kif.multi_key), 32'h1);
    goto_cyc(960); chk("multi_hold", 32'(kif.multi_key), 32'h1);
    chk("multi_no_held", 32'(kif.key_held), 32'h0);
    keys[15] = 1'b0;
    push(4'h0, 1008);
    goto_cyc(976);  chk("multi_off", 32'(kif.multi_key), 32'h0);
    goto_cyc(1024); chk("held_0", 32'(kif.key_held), 32'h1);
    keys[0] = 1'b0;
    goto_cyc(1072); chk("held_0_fall", 32'(kif.key_held), 32'h0);

    // Key 5 for two frames, then reset mid-debounce.
    keys[5] = 1'b1;
    goto_cyc(1109);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_col", 32'(kif.col_out), 32'h e);
    chk("mid_rst_held", 32'(kif.key_held), 32'h0);
    chk("mid_rst_en", 32'(kif.keypad_enable), 32'h0);
    chk("mid_rst_data", 32'(kif.keypad_data), 32'h0);
    reset = 1'b0;
    push(4'h5, 48);
    goto_cyc(32); chk("redeb_held", 32'(kif.key_held), 32'h0);
    goto_cyc(64); chk("redeb_held5", 32'(kif.key_held), 32'h1);
    chk("redeb_data", 32'(kif.keypad_data), 32'h5);
    keys[5] = 1'b0;
    goto_cyc(112); chk("held_5_fall", 32'(kif.key_held), 32'h0);

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
